// File: rtl/sram_word_fifo.sv
// sram_word_fifo
//   Word FIFO backed by an external asynchronous 16-bit SRAM. Each 32-bit
//   input word is stored as two halfwords (word n -> halfwords 2n and 2n+1,
//   low half first) in a circular buffer. Words are read back in order into
//   a one-word output register.
//
//   Optional feature macro: SRAM_FIFO_DROP_EN
//     defined   : the source is never stalled by a full FIFO. Words offered
//                 while full are accepted and discarded, and LOST_COUNT
//                 counts them, saturating at 255.
//     undefined : plain backpressure. LOST_COUNT is constant 0.
//
// Ports
//   BUS_CLK, BUS_RST_B      clock, asynchronous active-low reset
//   IN_DATA/VALID/READY     write-side valid/ready stream
//   OUT_DATA/VALID/READY    read-side valid/ready stream (registered)
//   SIZE                    words held in SRAM (output register excluded)
//   LOST_COUNT              discarded-word counter (drop mode only)
//   SRAM_*                  external SRAM pins
module sram_word_fifo #(
    parameter int ADDR_BITS = 20
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST_B,
    input  logic [31:0]          IN_DATA,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    output logic [31:0]          OUT_DATA,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [ADDR_BITS-1:0] SIZE,
    output logic [7:0]           LOST_COUNT,
    output logic [ADDR_BITS-1:0] SRAM_A,
    inout  wire  [15:0]          SRAM_IO,
    output logic                 SRAM_BHE_B,
    output logic                 SRAM_BLE_B,
    output logic                 SRAM_CE1_B,
    output logic                 SRAM_OE_B,
    output logic                 SRAM_WE_B
);

    localparam logic [ADDR_BITS-1:0] CAP = {1'b1, {(ADDR_BITS-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, WR_LO_S, WR_LO_W, WR_HI_S, WR_HI_W, RD_LO, RD_HI, RD_DONE
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_BITS-1:0] wr_ptr, rd_ptr, count, size_q;
    logic                 full, empty;
    logic                 wr_req, rd_req, grant_wr, grant_rd, prefer_wr;
    logic                 in_wr_state, in_ready;
    logic [31:0]          wr_data, wr_src, out_data_q;
    logic [15:0]          rd_lo, rd_hi;
    logic                 out_valid_q;
    logic                 io_drive;
    logic [15:0]          io_out;
    logic [ADDR_BITS-1:0] sram_a_c;
    logic                 ce_b, oe_b, we_b;

`ifdef SRAM_FIFO_DROP_EN
    logic        pend_valid;
    logic [31:0] pend_data;
    logic        accept, direct, store_pend, drop;
    logic [7:0]  lost_q;
`endif

    // Occupancy and arbitration
    always_comb begin
        count       = wr_ptr - rd_ptr;
        empty       = (count == '0);
        full        = (count == CAP);
        in_wr_state = (state == WR_LO_S) || (state == WR_LO_W) ||
                      (state == WR_HI_S) || (state == WR_HI_W);
        rd_req      = !empty && (!out_valid_q || OUT_READY);
`ifdef SRAM_FIFO_DROP_EN
        in_ready    = BUS_RST_B && !in_wr_state;
        accept      = IN_VALID && in_ready;
        wr_req      = pend_valid || (accept && !full);
`else
        wr_req      = IN_VALID && !full;
`endif
        grant_wr    = (state == IDLE) && wr_req && (!rd_req || prefer_wr);
        grant_rd    = (state == IDLE) && rd_req && !grant_wr;
`ifdef SRAM_FIFO_DROP_EN
        // A word taken while a read (or the pending slot) is busy parks in
        // pend; it is only kept if the SRAM still has room for it on top of
        // any write being started from pend in the same cycle.
        wr_src      = pend_valid ? pend_data : IN_DATA;
        direct      = grant_wr && !pend_valid;
        if (grant_wr && pend_valid)
            store_pend = accept && (count < (CAP - ADDR_BITS'(1)));
        else
            store_pend = accept && !direct && !pend_valid && !full;
        drop        = accept && !direct && !store_pend;
`else
        wr_src      = IN_DATA;
        in_ready    = BUS_RST_B && grant_wr;
`endif
    end

    // Next state and SRAM pin decode
    always_comb begin
        state_nxt = state;
        sram_a_c  = '0;
        io_drive  = 1'b0;
        io_out    = '0;
        ce_b      = 1'b1;
        oe_b      = 1'b1;
        we_b      = 1'b1;
        case (state)
            IDLE: begin
                if (grant_wr)      state_nxt = WR_LO_S;
                else if (grant_rd) state_nxt = RD_LO;
            end
            WR_LO_S: begin
                ce_b      = 1'b0;
                sram_a_c  = {wr_ptr[ADDR_BITS-2:0], 1'b0};
                io_drive  = 1'b1;
                io_out    = wr_data[15:0];
                state_nxt = WR_LO_W;
            end
            WR_LO_W: begin
                ce_b      = 1'b0;
                we_b      = 1'b0;
                sram_a_c  = {wr_ptr[ADDR_BITS-2:0], 1'b0};
                io_drive  = 1'b1;
                io_out    = wr_data[15:0];
                state_nxt = WR_HI_S;
            end
            WR_HI_S: begin
                ce_b      = 1'b0;
                sram_a_c  = {wr_ptr[ADDR_BITS-2:0], 1'b1};
                io_drive  = 1'b1;
                io_out    = wr_data[31:16];
                state_nxt = WR_HI_W;
            end
            WR_HI_W: begin
                ce_b      = 1'b0;
                we_b      = 1'b0;
                sram_a_c  = {wr_ptr[ADDR_BITS-2:0], 1'b1};
                io_drive  = 1'b1;
                io_out    = wr_data[31:16];
                state_nxt = IDLE;
            end
            RD_LO: begin
                ce_b      = 1'b0;
                oe_b      = 1'b0;
                sram_a_c  = {rd_ptr[ADDR_BITS-2:0], 1'b0};
                state_nxt = RD_HI;
            end
            RD_HI: begin
                ce_b      = 1'b0;
                oe_b      = 1'b0;
                sram_a_c  = {rd_ptr[ADDR_BITS-2:0], 1'b1};
                state_nxt = RD_DONE;
            end
            RD_DONE: begin
                ce_b      = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
        if (!BUS_RST_B) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            size_q      <= '0;
            prefer_wr   <= 1'b1;
            wr_data     <= '0;
            rd_lo       <= '0;
            rd_hi       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef SRAM_FIFO_DROP_EN
            pend_valid  <= 1'b0;
            pend_data   <= '0;
            lost_q      <= '0;
`endif
        end else begin
            state  <= state_nxt;
            size_q <= count;
            // Whoever wins now yields the next contended grant.
            if (grant_wr || grant_rd)
                prefer_wr <= !grant_wr;
            if (grant_wr)
                wr_data <= wr_src;
            if (state == WR_HI_W)
                wr_ptr <= wr_ptr + ADDR_BITS'(1);
            if (state == RD_LO)
                rd_lo <= SRAM_IO;
            if (state == RD_HI)
                rd_hi <= SRAM_IO;
            if (state == RD_DONE) begin
                out_data_q  <= {rd_hi, rd_lo};
                out_valid_q <= 1'b1;
                rd_ptr      <= rd_ptr + ADDR_BITS'(1);
            end else if (out_valid_q && OUT_READY) begin
                out_valid_q <= 1'b0;
            end
`ifdef SRAM_FIFO_DROP_EN
            if (store_pend) begin
                pend_valid <= 1'b1;
                pend_data  <= IN_DATA;
            end else if (grant_wr && pend_valid) begin
                pend_valid <= 1'b0;
            end
            if (drop && (lost_q != 8'hFF))
                lost_q <= lost_q + 8'd1;
`endif
        end
    end

    assign IN_READY   = in_ready;
    assign OUT_DATA   = out_data_q;
    assign OUT_VALID  = out_valid_q;
    assign SIZE       = size_q;
`ifdef SRAM_FIFO_DROP_EN
    assign LOST_COUNT = lost_q;
`else
    assign LOST_COUNT = '0;
`endif
    assign SRAM_A     = sram_a_c;
    assign SRAM_IO    = io_drive ? io_out : 'z;
    assign SRAM_BHE_B = 1'b0;
    assign SRAM_BLE_B = 1'b0;
    assign SRAM_CE1_B = ce_b;
    assign SRAM_OE_B  = oe_b;
    assign SRAM_WE_B  = we_b;

endmodule

// File: tb/tb_sram_word_fifo.sv
// Testbench for sram_word_fifo with a small asynchronous SRAM model and a
// queue-based reference of the words the FIFO should hold.
module tb_sram_word_fifo;
    localparam int AB  = 4;
    localparam int CAP = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data;
    logic        in_valid, in_ready;
    logic [31:0] out_data;
    logic        out_valid, out_ready;
    logic [AB-1:0] size, sram_a;
    logic [7:0]  lost;
    wire  [15:0] sram_io;
    logic        bhe_b, ble_b, ce_b, oe_b, we_b;

    logic [15:0] mem [0:(1<<AB)-1];

    always #5 clk = ~clk;

    sram_word_fifo #(.ADDR_BITS(AB)) dut (
        .BUS_CLK(clk), .BUS_RST_B(rst_n),
        .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
        .OUT_DATA(out_data), .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .SIZE(size), .LOST_COUNT(lost),
        .SRAM_A(sram_a), .SRAM_IO(sram_io),
        .SRAM_BHE_B(bhe_b), .SRAM_BLE_B(ble_b), .SRAM_CE1_B(ce_b),
        .SRAM_OE_B(oe_b), .SRAM_WE_B(we_b)
    );

    // SRAM model: drives the bus while output-enabled, stores while WE low.
    assign sram_io = (!ce_b && !oe_b && we_b) ? mem[sram_a] : 'z;
    always @(negedge clk)
        if (!ce_b && !we_b) mem[sram_a] <= sram_io;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: ordered list of words that must eventually appear at OUT.
    logic [31:0] mq[$];
    int unsigned n_popped = 0;
    int unsigned lost_exp = 0;
    logic        op_log_en = 1'b0;
    bit          ops_wr[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (mq.size() == 0) begin
                    check("out_extra", out_valid, 0);
                end else begin
                    check("out_data", out_data, mq.pop_front());
                    n_popped++;
                end
            end
            if (in_valid && in_ready) begin
`ifdef SRAM_FIFO_DROP_EN
                if (mq.size() < CAP + 1) mq.push_back(in_data);
                else if (lost_exp < 255) lost_exp++;
`else
                mq.push_back(in_data);
`endif
            end
            if (!we_b || !oe_b)
                check("we_oe_excl", (!we_b && !oe_b), 0);
            if (op_log_en && !sram_a[0]) begin
                if (!we_b)      ops_wr.push_back(1'b1);
                else if (!oe_b) ops_wr.push_back(1'b0);
            end
        end
    end

    task automatic push(input logic [31:0] w);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("push_accepted", done, 1);
    endtask

    task automatic drain(input int unsigned budget);
        bit done = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < int'(budget) && !done; i++) begin
            @(negedge clk);
            if (mq.size() == 0) done = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drain_done", done, 1);
    endtask

    task automatic quiesce(input string tag);
        int unsigned held;
        repeat (20) @(posedge clk);
        #1;
        held = mq.size();
        check({tag, "_size"}, size, (held > 0) ? held - 1 : 0);
        check({tag, "_out_valid"}, out_valid, (held > 0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned base, rep;
        bit seen;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < (1 << AB); i++) mem[i] = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_size", size, 0);
        check("rst_lost", lost, 0);
        check("rst_sram_a", sram_a, 0);
        check("rst_ctl", {bhe_b, ble_b, ce_b, oe_b, we_b}, 5'b00111);
        in_valid = 1'b1;
        #1 check("rst_in_ready_valid", in_ready, 0);
        in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

`ifndef SRAM_FIFO_DROP_EN
        // Single word with latency and storage layout
        push(32'hDEADBEEF);
        repeat (4) @(posedge clk);
        #1;
        check("sw_mem0", mem[0], 32'h0000BEEF);
        check("sw_mem1", mem[1], 32'h0000DEAD);
        @(posedge clk); #1;
        check("sw_size1", size, 1);
        check("sw_valid_early", out_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        check("sw_valid_edge3", out_valid, 0);
        @(posedge clk); #1;
        check("sw_valid_edge4", out_valid, 1);
        check("sw_out_data", out_data, 32'hDEADBEEF);
        @(posedge clk); #1;
        check("sw_size0", size, 0);
        repeat (10) @(posedge clk);
        #1;
        check("sw_hold", out_valid, 1);
        drain(50);
        quiesce("single");

        // Burst of 100 with consumer always ready
        base = n_popped;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) push(32'(i));
        drain(400);
        check("burst_count", n_popped - base, 100);
        quiesce("burst");

        // Contended arbitration: backlog first, then both sides active
        for (int i = 0; i < 4; i++) push(32'h1000 + 32'(i));
        ops_wr.delete();
        op_log_en = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 24; i++) push(32'h2000 + 32'(i));
        op_log_en = 1'b0;
        rep = 0;
        for (int k = 1; k < ops_wr.size(); k++)
            if (ops_wr[k] == ops_wr[k-1]) rep++;
        check("arb_repeats", rep, 0);
        check("arb_ops_seen", (ops_wr.size() >= 40), 1);
        drain(400);
        quiesce("arb");

        // Full: 9 words fit (8 in SRAM + output register), 10th blocked
        for (int i = 0; i < 9; i++) push(32'hA000 + 32'(i));
        quiesce("full");
        in_valid = 1'b1;
        in_data  = 32'hBAD0BAD0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) seen = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("full_blocks", seen, 0);
        check("full_lost", lost, 0);

        // Drain and refill across the address wrap
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) push($urandom);
        drain(400);
        quiesce("wrap");

        // Reset during the low-half write strobe
        push(32'hCAFEF00D);
        @(posedge clk); #1;
        check("mid_we_low", we_b, 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_we", we_b, 1);
        check("mid_rst_oe", oe_b, 1);
        check("mid_rst_ce", ce_b, 1);
        mq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        quiesce("post_rst");
        check("post_rst_data", out_data, 0);
`else
        // Drop mode: 300 spaced offers with the consumer stalled
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = 32'h100 + 32'(i) + ($urandom << 16);
            @(negedge clk);
            check("drop_ready", in_ready, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (6) @(posedge clk);
        end
        quiesce("drop_full");
        check("drop_lost", lost, lost_exp);
        check("drop_lost_sat", lost_exp, 255);
        base = n_popped;
        drain(400);
        check("drop_readback", n_popped - base, CAP + 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
